// File: rtl/alu_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch_pkg
// Description : Shared ALU control-bit, status-flag and width constants
//               plus small decode helpers for the ALU dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_dispatch_pkg;

    localparam int ALU_CNTL_W = 14;
    localparam int STAT_W     = 6;
    localparam int DATA_W     = 32;

    // ALU control word bit positions
    localparam int ALU_OP_ADD    = 0;
    localparam int ALU_OP_SUB    = 1;
    localparam int ALU_OP_AND    = 2;
    localparam int ALU_OP_OR     = 3;
    localparam int ALU_OP_XOR    = 4;
    localparam int ALU_OP_MUL    = 5;
    localparam int ALU_OP_DIV    = 6;
    localparam int ALU_USE_CARRY = 7;
    localparam int ALU_NO_WR     = 8;

    // Status register bit positions
    localparam int STAT_CF = 0;
    localparam int STAT_PF = 1;
    localparam int STAT_AF = 2;
    localparam int STAT_ZF = 3;
    localparam int STAT_SF = 4;
    localparam int STAT_OF = 5;

    function automatic logic is_basic_op(input logic [ALU_CNTL_W-1:0] cntl);
        return cntl[ALU_OP_ADD] | cntl[ALU_OP_SUB] | cntl[ALU_OP_AND] |
               cntl[ALU_OP_OR]  | cntl[ALU_OP_XOR];
    endfunction

    function automatic logic is_div_op(input logic [ALU_CNTL_W-1:0] cntl);
        return cntl[ALU_OP_DIV];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch_if
// Description : Request, ALU-drive and response channels of the dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_dispatch_if;
    import alu_dispatch_pkg::*;

    logic                  flush;
    logic                  req_valid;
    logic                  req_ready;
    logic [ALU_CNTL_W-1:0] req_cntl;
    logic [DATA_W-1:0]     req_opnd0;
    logic [DATA_W-1:0]     req_opnd1;
    logic [ALU_CNTL_W-1:0] alu_cntl;
    logic [DATA_W-1:0]     alu_opnd0;
    logic [DATA_W-1:0]     alu_opnd1;
    logic [STAT_W-1:0]     alu_status_in;
    logic [STAT_W-1:0]     alu_status_out;
    logic [DATA_W-1:0]     alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_result;
    logic [STAT_W-1:0]     rsp_status;
    logic                  rsp_fault;
    logic [STAT_W-1:0]     flags_q;

    // Dispatcher side
    modport slave (
        input  flush, req_valid, req_cntl, req_opnd0, req_opnd1,
               alu_status_out, alu_result, rsp_ready,
        output req_ready, alu_cntl, alu_opnd0, alu_opnd1, alu_status_in,
               rsp_valid, rsp_result, rsp_status, rsp_fault, flags_q
    );

    // Execute-stage side (issues requests, hosts the ALU, consumes responses)
    modport master (
        output flush, req_valid, req_cntl, req_opnd0, req_opnd1,
               alu_status_out, alu_result, rsp_ready,
        input  req_ready, alu_cntl, alu_opnd0, alu_opnd1, alu_status_in,
               rsp_valid, rsp_result, rsp_status, rsp_fault, flags_q
    );

endinterface
`default_nettype wire

// File: rtl/alu_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : alu_lat_counter
// Description : Loadable down-counter timing how long ALU inputs are held.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_lat_counter #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic                  o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Done marks the final held cycle; capture happens on the same edge
    assign o_done = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch
// Description : Sequential front end that issues one op at a time to the
//               combinational ALU, owns the status register, times MUL/DIV
//               latency and returns result/flags/fault on a response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 8,
    parameter int BASIC_LAT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_dispatch_if.slave bus
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ?
                               ((MUL_LAT > BASIC_LAT) ? MUL_LAT : BASIC_LAT) :
                               ((DIV_LAT > BASIC_LAT) ? DIV_LAT : BASIC_LAT);
    localparam int c_CNT_W = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MUL_LAT   = c_CNT_W'(MUL_LAT);
    localparam logic [c_CNT_W-1:0] c_DIV_LAT   = c_CNT_W'(DIV_LAT);
    localparam logic [c_CNT_W-1:0] c_BASIC_LAT = c_CNT_W'(BASIC_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_result;
    logic [STAT_W-1:0]     r_rsp_status;
    logic                  r_rsp_fault;
    logic [STAT_W-1:0]     r_flags_q;
    logic [ALU_CNTL_W-1:0] r_alu_cntl;
    logic [DATA_W-1:0]     r_alu_opnd0;
    logic [DATA_W-1:0]     r_alu_opnd1;

    logic                  w_accept;
    logic                  w_div_zero;
    logic                  w_capture;
    logic                  w_cnt_done;
    logic                  w_cnt_load;
    logic [c_CNT_W-1:0]    w_cnt_load_val;
    logic [c_CNT_W-1:0]    w_req_lat;

    always_comb begin
        if (bus.req_cntl[ALU_OP_MUL]) begin
            w_req_lat = c_MUL_LAT;
        end else if (!is_basic_op(bus.req_cntl)) begin
            w_req_lat = c_DIV_LAT;
        end else begin
            w_req_lat = c_BASIC_LAT;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid && r_req_ready && !bus.flush;
    // A zero divisor is known from the latched operands, so no need to wait
    assign w_div_zero = is_div_op(r_alu_cntl) && (r_alu_opnd1 == '0);
    assign w_capture  = (r_state == S_EXEC) && (w_cnt_done || w_div_zero);

    assign w_cnt_load     = w_accept || bus.flush;
    assign w_cnt_load_val = bus.flush ? '0 : w_req_lat;

    alu_lat_counter #(
        .CNT_W (c_CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (r_state == S_EXEC),
        .o_done     (w_cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
            r_rsp_fault  <= 1'b0;
            r_flags_q    <= '0;
            r_alu_cntl   <= '0;
            r_alu_opnd0  <= '0;
            r_alu_opnd1  <= '0;
        end else if (bus.flush) begin
            // Flush wins over capture and handshake; flags_q keeps its value
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_cntl  <= bus.req_cntl;
                        r_alu_opnd0 <= bus.req_opnd0;
                        r_alu_opnd1 <= bus.req_opnd1;
                        r_req_ready <= 1'b0;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_capture) begin
                        if (w_div_zero) begin
                            r_rsp_result <= '0;
                            r_rsp_status <= r_flags_q;
                            r_rsp_fault  <= 1'b1;
                        end else begin
                            r_rsp_result <= bus.alu_result;
                            r_rsp_status <= bus.alu_status_out;
                            r_flags_q    <= bus.alu_status_out;
                            r_rsp_fault  <= 1'b0;
                        end
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_result    = r_rsp_result;
    assign bus.rsp_status    = r_rsp_status;
    assign bus.rsp_fault     = r_rsp_fault;
    assign bus.flags_q       = r_flags_q;
    assign bus.alu_cntl      = r_alu_cntl;
    assign bus.alu_opnd0     = r_alu_opnd0;
    assign bus.alu_opnd1     = r_alu_opnd1;
    assign bus.alu_status_in = r_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_dispatch
// Description : Bench for alu_dispatch: behavioural ALU stand-in, reference
//               flag/latency model, directed and random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_dispatch;
    import alu_dispatch_pkg::*;

    localparam logic [13:0] C_ADD = 14'(1 << ALU_OP_ADD);
    localparam logic [13:0] C_SUB = 14'(1 << ALU_OP_SUB);
    localparam logic [13:0] C_AND = 14'(1 << ALU_OP_AND);
    localparam logic [13:0] C_OR  = 14'(1 << ALU_OP_OR);
    localparam logic [13:0] C_XOR = 14'(1 << ALU_OP_XOR);
    localparam logic [13:0] C_MUL = 14'(1 << ALU_OP_MUL);
    localparam logic [13:0] C_DIV = 14'(1 << ALU_OP_DIV);
    localparam logic [13:0] C_CY  = 14'(1 << ALU_USE_CARRY);
    localparam logic [13:0] C_NWR = 14'(1 << ALU_NO_WR);

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [5:0] ref_flags;

    alu_dispatch_if bus ();

    alu_dispatch #(
        .MUL_LAT   (3),
        .DIV_LAT   (8),
        .BASIC_LAT (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {status, result}
    function automatic logic [37:0] alu_fn(input logic [13:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [5:0] st);
        logic [32:0] wide;
        logic [63:0] prod;
        logic [31:0] r;
        logic [5:0]  f;
        logic        cin;
        f    = st;
        r    = '0;
        cin  = c[ALU_USE_CARRY] ? st[STAT_CF] : 1'b0;
        wide = '0;
        prod = '0;
        if (c[ALU_NO_WR]) return {st, 32'd0};
        if (c[ALU_OP_ADD]) begin
            wide = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r = wide[31:0];
            f[STAT_CF] = wide[32];
            f[STAT_OF] = (a[31] == b[31]) && (r[31] != a[31]);
            f[STAT_AF] = a[4] ^ b[4] ^ r[4];
        end else if (c[ALU_OP_SUB]) begin
            wide = {1'b0, a} - {1'b0, b} - {32'd0, cin};
            r = wide[31:0];
            f[STAT_CF] = wide[32];
            f[STAT_OF] = (a[31] != b[31]) && (r[31] != a[31]);
            f[STAT_AF] = a[4] ^ b[4] ^ r[4];
        end else if (c[ALU_OP_AND] | c[ALU_OP_OR] | c[ALU_OP_XOR]) begin
            r = c[ALU_OP_AND] ? (a & b) : (c[ALU_OP_OR] ? (a | b) : (a ^ b));
            f[STAT_CF] = 1'b0;
            f[STAT_OF] = 1'b0;
            f[STAT_AF] = 1'b0;
        end else if (c[ALU_OP_MUL]) begin
            prod = {32'd0, a} * {32'd0, b};
            r = prod[31:0];
            f[STAT_CF] = |prod[63:32];
            f[STAT_OF] = |prod[63:32];
            f[STAT_AF] = 1'b0;
        end else begin
            r = (b != 0) ? (a / b) : 32'd0;
            f[STAT_CF] = 1'b0;
            f[STAT_OF] = 1'b0;
            f[STAT_AF] = 1'b0;
        end
        f[STAT_ZF] = (r == 0);
        f[STAT_SF] = r[31];
        f[STAT_PF] = ~^r[7:0];
        return {f, r};
    endfunction

    always_comb begin
        {bus.alu_status_out, bus.alu_result} =
            alu_fn(bus.alu_cntl, bus.alu_opnd0, bus.alu_opnd1, bus.alu_status_in);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [13:0] c, input logic [31:0] b);
        if (c[ALU_OP_MUL]) return 3;
        if (c[ALU_OP_ADD] | c[ALU_OP_SUB] | c[ALU_OP_AND] | c[ALU_OP_OR] | c[ALU_OP_XOR])
            return 1;
        if (c[ALU_OP_DIV] && b == 0) return 1;
        return 8;
    endfunction

    // Issue one op, check latency/response, hold the response for `stall` cycles.
    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [13:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int stall);
        logic [37:0] e;
        logic [31:0] e_res;
        logic [5:0]  e_st;
        logic        e_fault;
        int          lat;
        if (c[ALU_OP_DIV] && !c[ALU_OP_MUL] && b == 0 &&
            !(c[ALU_OP_ADD] | c[ALU_OP_SUB] | c[ALU_OP_AND] | c[ALU_OP_OR] | c[ALU_OP_XOR])) begin
            e_res = 32'd0; e_st = ref_flags; e_fault = 1'b1;
        end else begin
            e = alu_fn(c, a, b, ref_flags);
            e_res = e[31:0]; e_st = e[37:32]; e_fault = 1'b0;
            ref_flags = e_st;
        end
        check("ready_idle", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_cntl  = c;
        bus.req_opnd0 = a;
        bus.req_opnd1 = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            check("ready_busy", {63'd0, bus.req_ready}, 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_latency(c, b)));
        check("rsp_result", {32'd0, bus.rsp_result}, {32'd0, e_res});
        check("rsp_status", {58'd0, bus.rsp_status}, {58'd0, e_st});
        check("rsp_fault", {63'd0, bus.rsp_fault}, {63'd0, e_fault});
        check("flags_q", {58'd0, bus.flags_q}, {58'd0, ref_flags});
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            bus.req_opnd0 = a ^ 32'h5A5A_0001;
            @(posedge clk); #1;
            check("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
            check("stall_result", {32'd0, bus.rsp_result}, {32'd0, e_res});
            check("stall_ready", {63'd0, bus.req_ready}, 64'd0);
            check("stall_no_accept", {32'd0, bus.alu_opnd0}, {32'd0, a});
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("rsp_drop", {63'd0, bus.rsp_valid}, 64'd0);
    endtask

    function automatic logic [13:0] rand_op(input int k);
        case (k)
            0: return C_ADD;
            1: return C_SUB;
            2: return C_AND;
            3: return C_OR;
            4: return C_XOR;
            5: return C_MUL;
            6: return C_DIV;
            7: return C_ADD | C_CY;
            8: return C_SUB | C_CY;
            default: return C_ADD | C_NWR;
        endcase
    endfunction

    initial begin
        logic [13:0] c;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  held;
        total = 0;
        bad = 0;
        ref_flags = '0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cntl = '0;
        bus.req_opnd0 = '0;
        bus.req_opnd1 = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_flags", {58'd0, bus.flags_q}, 64'd0);
        check("rst_alu_cntl", {50'd0, bus.alu_cntl}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD wrap: result 0 with CF/ZF/PF set
        run_op(C_ADD, 32'hFFFF_FFFF, 32'd1, 0);
        check("wrap_flags", {58'd0, bus.flags_q[STAT_CF], bus.flags_q[STAT_ZF],
                             bus.flags_q[STAT_PF], bus.flags_q[STAT_SF]}, 64'b1110);
        // Chained carry: 1+1+CF
        run_op(C_ADD | C_CY, 32'd1, 32'd1, 0);
        check("adc_result", {32'd0, bus.rsp_result}, 64'd3);
        run_op(C_MUL, 32'd3, 32'd5, 0);
        check("mul_result", {32'd0, bus.rsp_result}, 64'd15);
        held = ref_flags;
        run_op(C_DIV, 32'd7, 32'd0, 0);
        check("div0_flags_kept", {58'd0, bus.flags_q}, {58'd0, held});
        run_op(C_DIV, 32'd100, 32'd7, 0);
        check("div_result", {32'd0, bus.rsp_result}, 64'd14);
        run_op(C_SUB, 32'd10, 32'd3, 4);

        for (int n = 0; n < 24; n++) begin
            c = rand_op(int'($urandom_range(0, 9)));
            a = $urandom;
            b = $urandom;
            if (c[ALU_OP_DIV]) b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            run_op(c, a, b, int'($urandom_range(0, 2)));
        end

        // Flush during DIV at its fourth EXEC cycle; a request alongside is ignored
        held = ref_flags;
        bus.req_valid = 1'b1;
        bus.req_cntl = C_DIV;
        bus.req_opnd0 = 32'd50;
        bus.req_opnd1 = 32'd5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_opnd0 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("flush_idle_ready", {63'd0, bus.req_ready}, 64'd1);
        check("flush_no_accept", {32'd0, bus.alu_opnd0}, 64'd50);
        check("flush_flags", {58'd0, bus.flags_q}, {58'd0, held});
        repeat (10) @(posedge clk);
        #1;
        check("flush_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);

        // Flush on the capture edge of a flag-changing ADD
        held = ref_flags;
        bus.req_valid = 1'b1;
        bus.req_cntl = C_ADD;
        bus.req_opnd0 = 32'h7FFF_FFFF;
        bus.req_opnd1 = (held[STAT_OF]) ? 32'd0 : 32'd1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_cap_flags", {58'd0, bus.flags_q}, {58'd0, held});
        check("flush_cap_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("flush_cap_fault", {63'd0, bus.rsp_fault}, 64'd0);

        // Make flags non-zero, then async reset in the middle of a MUL
        run_op(C_SUB, 32'd0, 32'd1, 0);
        bus.req_valid = 1'b1;
        bus.req_cntl = C_MUL;
        bus.req_opnd0 = 32'd9;
        bus.req_opnd1 = 32'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("arst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("arst_rsp_result", {32'd0, bus.rsp_result}, 64'd0);
        check("arst_flags", {58'd0, bus.flags_q}, 64'd0);
        check("arst_status_in", {58'd0, bus.alu_status_in}, 64'd0);
        check("arst_opnd0", {32'd0, bus.alu_opnd0}, 64'd0);
        check("arst_cntl", {50'd0, bus.alu_cntl}, 64'd0);
        ref_flags = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(C_ADD | C_CY, 32'd2, 32'd3, 0);
        check("post_rst_result", {32'd0, bus.rsp_result}, 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
